// File: rtl/idct8_skew_feeder.sv
// idct8_skew_feeder
//   Upstream feeder for the 8-point systolic IDCT column unit. It accepts one
//   8-coefficient row per cycle and re-emits it diagonally skewed, so lane k
//   leaves k-1 cycles after lane 1. The add/shift constants for the active
//   pass, plus the valid and block-last tags, travel with lane 8.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   in_valid       row present on in_row_*
//   in_ready       feeder accepts a row this cycle (combinational)
//   in_row_1..8    signed row coefficients
//   pass_req       requested pass (0 = column pass, 1 = row pass)
//   d_in_1..8      skewed lanes to the IDCT unit (0 on bubbles)
//   add, shift     rounding constant / shift for the lane-8 slot's pass
//   lane8_valid    d_in_8 carries a real row
//   block_last     d_in_8 carries row ROWS-1 of a block
//   pass           currently active pass
//   busy           any lane slot holds valid data
//
// state   | meaning
// S_RUN   | accepting rows for the active pass
// S_DRAIN | pass change pending; waiting for every lane slot to empty

module idct8_skew_feeder #(
  parameter int W      = 25,
  parameter int ADD1   = 64,
  parameter int SHIFT1 = 7,
  parameter int ADD2   = 2048,
  parameter int SHIFT2 = 12,
  parameter int ROWS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_row_1,
  input  logic signed [W-1:0] in_row_2,
  input  logic signed [W-1:0] in_row_3,
  input  logic signed [W-1:0] in_row_4,
  input  logic signed [W-1:0] in_row_5,
  input  logic signed [W-1:0] in_row_6,
  input  logic signed [W-1:0] in_row_7,
  input  logic signed [W-1:0] in_row_8,
  input  logic                pass_req,
  output logic signed [W-1:0] d_in_1,
  output logic signed [W-1:0] d_in_2,
  output logic signed [W-1:0] d_in_3,
  output logic signed [W-1:0] d_in_4,
  output logic signed [W-1:0] d_in_5,
  output logic signed [W-1:0] d_in_6,
  output logic signed [W-1:0] d_in_7,
  output logic signed [W-1:0] d_in_8,
  output logic signed [W-1:0] add,
  output logic signed [3:0]   shift,
  output logic                lane8_valid,
  output logic                block_last,
  output logic                pass,
  output logic                busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t          r_state;
  logic            r_pass;
  logic [RW-1:0]   r_row;
  logic            w_accept;
  logic            w_busy;
  logic signed [W-1:0] w_row      [8];
  logic signed [W-1:0] w_lane_out [8];
  logic [7:0]          w_lane_busy;

  assign w_row[0] = in_row_1;
  assign w_row[1] = in_row_2;
  assign w_row[2] = in_row_3;
  assign w_row[3] = in_row_4;
  assign w_row[4] = in_row_5;
  assign w_row[5] = in_row_6;
  assign w_row[6] = in_row_7;
  assign w_row[7] = in_row_8;

  assign in_ready = (r_state == S_RUN) && (pass_req == r_pass);
  assign w_accept = in_valid && in_ready;

  // Triangular delay: lane k (0-based) holds k+1 stages. A bubble loads zero
  // data, so an empty slot never contributes to the IDCT sum.
  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic signed [W-1:0] r_d [k+1];
    logic [k:0]          r_v;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_d[0] <= '0;
        r_v[0] <= 1'b0;
      end else begin
        r_d[0] <= w_accept ? w_row[k] : '0;
        r_v[0] <= w_accept;
      end
    end

    for (genvar s = 1; s <= k; s++) begin : g_stage
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_d[s] <= '0;
          r_v[s] <= 1'b0;
        end else begin
          r_d[s] <= r_d[s-1];
          r_v[s] <= r_v[s-1];
        end
      end
    end

    assign w_lane_out[k]  = r_d[k];
    assign w_lane_busy[k] = |r_v;
  end

  assign d_in_1 = w_lane_out[0];
  assign d_in_2 = w_lane_out[1];
  assign d_in_3 = w_lane_out[2];
  assign d_in_4 = w_lane_out[3];
  assign d_in_5 = w_lane_out[4];
  assign d_in_6 = w_lane_out[5];
  assign d_in_7 = w_lane_out[6];
  assign d_in_8 = w_lane_out[7];

  assign w_busy = |w_lane_busy;
  assign busy   = w_busy;

  // Lane-8 side pipeline: row index, pass and valid follow the lane-8 data
  // through seven stages; the eighth stage is the registered tag/constant
  // outputs so they switch on the same edge as d_in_8. Bubbles carry the
  // pass current at their entry so add/shift stay defined between rows.
  logic          r_mv   [7];
  logic [RW-1:0] r_midx [7];
  logic          r_mp   [7];
  logic                r_l8_valid;
  logic                r_block_last;
  logic signed [W-1:0] r_add;
  logic signed [3:0]   r_shift;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 7; s++) begin
        r_mv[s]   <= 1'b0;
        r_midx[s] <= '0;
        r_mp[s]   <= 1'b0;
      end
      r_l8_valid   <= 1'b0;
      r_block_last <= 1'b0;
      r_add        <= W'(ADD1);
      r_shift      <= 4'(SHIFT1);
    end else begin
      r_mv[0]   <= w_accept;
      r_midx[0] <= r_row;
      r_mp[0]   <= r_pass;
      for (int s = 1; s < 7; s++) begin
        r_mv[s]   <= r_mv[s-1];
        r_midx[s] <= r_midx[s-1];
        r_mp[s]   <= r_mp[s-1];
      end
      r_l8_valid   <= r_mv[6];
      r_block_last <= r_mv[6] && (r_midx[6] == RW'(ROWS - 1));
      r_add        <= r_mp[6] ? W'(ADD2) : W'(ADD1);
      r_shift      <= r_mp[6] ? 4'(SHIFT2) : 4'(SHIFT1);
    end
  end

  assign lane8_valid = r_l8_valid;
  assign block_last  = r_block_last;
  assign add         = r_add;
  assign shift       = r_shift;
  assign pass        = r_pass;

  // Pass sequencing. A pass change only takes effect once every slot is
  // empty; the row counter is cleared on exit so a partial block is dropped
  // and never produces block_last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_pass  <= 1'b0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept)
            r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
          if (pass_req != r_pass)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!w_busy) begin
            r_pass  <= pass_req;
            r_row   <= '0;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_idct8_skew_feeder.sv
module tb_idct8_skew_feeder;

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic pass_req;
  logic signed [24:0] rv [1:8];
  logic signed [24:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic signed [24:0] dv [1:8];
  logic signed [24:0] add_o;
  logic signed [3:0]  shift_o;
  logic lane8_valid, block_last, pass_o, busy;

  int total = 0;
  int bad   = 0;

  idct8_skew_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row_1   (rv[1]),
    .in_row_2   (rv[2]),
    .in_row_3   (rv[3]),
    .in_row_4   (rv[4]),
    .in_row_5   (rv[5]),
    .in_row_6   (rv[6]),
    .in_row_7   (rv[7]),
    .in_row_8   (rv[8]),
    .pass_req   (pass_req),
    .d_in_1     (d1),
    .d_in_2     (d2),
    .d_in_3     (d3),
    .d_in_4     (d4),
    .d_in_5     (d5),
    .d_in_6     (d6),
    .d_in_7     (d7),
    .d_in_8     (d8),
    .add        (add_o),
    .shift      (shift_o),
    .lane8_valid(lane8_valid),
    .block_last (block_last),
    .pass       (pass_o),
    .busy       (busy)
  );

  assign dv[1] = d1;
  assign dv[2] = d2;
  assign dv[3] = d3;
  assign dv[4] = d4;
  assign dv[5] = d5;
  assign dv[6] = d6;
  assign dv[7] = d7;
  assign dv[8] = d8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int base);
    for (int k = 1; k <= 8; k++) rv[k] = 25'(base + k);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    pass_req = 1'b0;
    set_row(-1);
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (dv[k] !== 25'sd0) begin
        bad++;
        $display("FAIL reset_lane%0d got=%0d exp=0", k, dv[k]);
      end
    end
    total++;
    if (lane8_valid !== 1'b0 || block_last !== 1'b0 || busy !== 1'b0 || pass_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got v=%b bl=%b busy=%b pass=%b exp all 0",
               lane8_valid, block_last, busy, pass_o);
    end
    total++;
    if (add_o !== 25'sd64 || shift_o !== 4'h7) begin
      bad++;
      $display("FAIL reset_consts got add=%0d shift=%0d exp add=64 shift=7", add_o, shift_o);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single_row();
    int exp_v;
    do_reset();
    for (int k = 1; k <= 8; k++) rv[k] = 25'(k * 10);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      for (int k = 1; k <= 8; k++) begin
        exp_v = (n == k) ? k * 10 : 0;
        total++;
        if (dv[k] !== 25'(exp_v)) begin
          bad++;
          $display("FAIL single_lane%0d cyc%0d got=%0d exp=%0d", k, n, dv[k], exp_v);
        end
      end
      total++;
      if (lane8_valid !== (n == 8) || block_last !== 1'b0) begin
        bad++;
        $display("FAIL single_tags cyc%0d got v=%b bl=%b exp v=%b bl=0",
                 n, lane8_valid, block_last, (n == 8));
      end
      if (n == 8) begin
        total++;
        if (add_o !== 25'sd64 || shift_o !== 4'h7) begin
          bad++;
          $display("FAIL single_consts got add=%0d shift=%0d exp add=64 shift=7", add_o, shift_o);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int r;
    int exp_v;
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      if (n <= 8) begin
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) rv[k] = 25'((n - 1) * 8 + k);
      end else begin
        in_valid = 1'b0;
      end
      step();
      for (int k = 1; k <= 8; k++) begin
        r = n - k;
        exp_v = (r >= 0 && r <= 7) ? r * 8 + k : 0;
        total++;
        if (dv[k] !== 25'(exp_v)) begin
          bad++;
          $display("FAIL b2b_lane%0d cyc%0d got=%0d exp=%0d", k, n, dv[k], exp_v);
        end
      end
      total++;
      if (lane8_valid !== (n >= 8 && n <= 15)) begin
        bad++;
        $display("FAIL b2b_valid cyc%0d got=%b exp=%b", n, lane8_valid, (n >= 8 && n <= 15));
      end
      total++;
      if (block_last !== (n == 15)) begin
        bad++;
        $display("FAIL b2b_block_last cyc%0d got=%b exp=%b", n, block_last, (n == 15));
      end
    end
  endtask

  task automatic test_pass_switch();
    int ra, jb, exp_v;
    logic exp_busy, exp_l8, exp_run;
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      in_valid = 1'b1;
      set_row(100 + (n - 1) * 8);
      step();
    end
    pass_req = 1'b1;
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) rv[k] = 25'h1FFFFFF;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL switch_ready_drop got=%b exp=0", in_ready);
    end
    for (int n = 4; n <= 28; n++) begin
      if (n <= 12) begin
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) rv[k] = 25'h1FFFFFF;
      end else if (n <= 20) begin
        in_valid = 1'b1;
        set_row(300 + (n - 13) * 8);
      end else begin
        in_valid = 1'b0;
      end
      step();
      for (int k = 1; k <= 8; k++) begin
        ra = n - k;
        jb = n - 12 - k;
        if (ra >= 0 && ra <= 2)      exp_v = 100 + ra * 8 + k;
        else if (jb >= 0 && jb <= 7) exp_v = 300 + jb * 8 + k;
        else                         exp_v = 0;
        total++;
        if (dv[k] !== 25'(exp_v)) begin
          bad++;
          $display("FAIL switch_lane%0d cyc%0d got=%0d exp=%0d", k, n, dv[k], exp_v);
        end
      end
      exp_busy = (n <= 10) || (n >= 13 && n <= 27);
      exp_run  = (n >= 12);
      exp_l8   = (n >= 8 && n <= 10) || (n >= 20 && n <= 27);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL switch_busy cyc%0d got=%b exp=%b", n, busy, exp_busy);
      end
      total++;
      if (in_ready !== exp_run || pass_o !== exp_run) begin
        bad++;
        $display("FAIL switch_ready_pass cyc%0d got rdy=%b pass=%b exp %b", n, in_ready, pass_o, exp_run);
      end
      total++;
      if (lane8_valid !== exp_l8 || block_last !== (n == 27)) begin
        bad++;
        $display("FAIL switch_tags cyc%0d got v=%b bl=%b exp v=%b bl=%b",
                 n, lane8_valid, block_last, exp_l8, (n == 27));
      end
      if (n >= 20 && n <= 27) begin
        total++;
        if (add_o !== 25'sd2048 || shift_o !== 4'hC) begin
          bad++;
          $display("FAIL switch_consts cyc%0d got add=%0d shift=%0d exp add=2048 shift=12",
                   n, add_o, shift_o);
        end
      end
      if (n >= 8 && n <= 10) begin
        total++;
        if (add_o !== 25'sd64 || shift_o !== 4'h7) begin
          bad++;
          $display("FAIL switch_old_consts cyc%0d got add=%0d shift=%0d exp add=64 shift=7",
                   n, add_o, shift_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pass_req = 1'b1;
    step();
    step();
    total++;
    if (pass_o !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_pass_setup got pass=%b rdy=%b exp 1 1", pass_o, in_ready);
    end
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1;
      set_row(500 + n * 8);
      step();
    end
    in_valid = 1'b0;
    pass_req = 1'b0;
    reset    = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (dv[k] !== 25'sd0) begin
        bad++;
        $display("FAIL mid_lane%0d got=%0d exp=0", k, dv[k]);
      end
    end
    total++;
    if (lane8_valid !== 1'b0 || busy !== 1'b0 || pass_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_flags got v=%b busy=%b pass=%b exp 0 0 0", lane8_valid, busy, pass_o);
    end
    total++;
    if (add_o !== 25'sd64 || shift_o !== 4'h7) begin
      bad++;
      $display("FAIL mid_consts got add=%0d shift=%0d exp add=64 shift=7", add_o, shift_o);
    end
    for (int n = 1; n <= 8; n++) begin
      step();
      total++;
      if ((d1 | d2 | d3 | d4 | d5 | d6 | d7 | d8) !== 25'sd0 || lane8_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_residue cyc%0d got or=%0d v=%b exp 0 0",
                 n, (d1 | d2 | d3 | d4 | d5 | d6 | d7 | d8), lane8_valid);
      end
    end
  endtask

  task automatic test_negative();
    logic signed [24:0] neg;
    neg = 25'h1000000;
    do_reset();
    for (int k = 1; k <= 8; k++) rv[k] = neg;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      total++;
      if (dv[n] !== neg || dv[n] >= 0) begin
        bad++;
        $display("FAIL neg_lane%0d got=%0d exp=-16777216", n, dv[n]);
      end
      step();
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    pass_req = 1'b0;
    set_row(0);
    test_reset();
    test_single_row();
    test_back_to_back();
    test_pass_switch();
    test_reset_mid();
    test_negative();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
